ped_req_cond: RTL and testbench
===============================

# ped_req_cond

Pedestrian request conditioner sitting directly upstream of the traffic-light controller. It synchronises and debounces the raw crossing button and turns each clean press into a held `ped` request level. The request is held until the controller signals that the pedestrian phase has been served, then a hold-off window blocks repeat presses. It also drives the "WAIT" indicator lamp on the button box.

## Interface
Parameters:
- `DB_CYCLES`, 4: consecutive stable cycles required before the debounced level changes; legal range 1..255.
- `HOLDOFF`, 8: cycles after the walk phase ends during which presses are ignored; 0 disables the hold-off; legal range 0..255.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` at top level).
- `btn_raw`  in  1  raw button, asynchronous, may bounce.
- `walk`  in  1  high while the controller runs the pedestrian crossing phase; synchronous to `clk`.
- `ped`  out  1  registered request level to the controller.
- `wait_lamp`  out  1  registered; lit while a request is pending.
- `btn_clean`  out  1  registered debounced button level.
- `press_cnt`  out  8  accepted-press counter (see Configuration).

## Operation
- Synchroniser: two flops `s1`, `s2` on `btn_raw`; only `s2` is used downstream.
- Debounce: 8-bit counter `dc`.
  - `dc` clears when `s2 == btn_clean`.
  - Otherwise `dc` increments.
  - When `dc == DB_CYCLES-1` and `s2 != btn_clean`, `btn_clean <= s2` and `dc <= 0`.
  - Result: a level is accepted after exactly `DB_CYCLES` consecutive mismatching cycles; any glitch shorter than that is discarded.
- Press: `press = btn_clean & ~btn_clean_d`, where `btn_clean_d` is a one-cycle delay; a single-cycle pulse.
- FSM states: IDLE, REQ, SERVE, HOLD.
  - IDLE: `press` -> REQ. `walk` alone is ignored.
  - REQ: `ped=1`, `wait_lamp=1`. `walk=1` -> SERVE. Further presses are ignored.
  - SERVE: `ped=0`, `wait_lamp=0`. `walk` falling (`walk=0`) -> HOLD with `hc <= 0`, or straight to IDLE if `HOLDOFF==0`. Presses are ignored.
  - HOLD: `hc` increments each cycle. `hc == HOLDOFF-1` -> IDLE. Presses are ignored and not remembered.
- `ped` and `wait_lamp` are registered and equal to (next state == REQ), so both are high in exactly the cycles the FSM is in REQ.
- Simultaneous `press` and `walk` in IDLE: press wins (-> REQ), then SERVE on the next edge if `walk` is still high.

## Timing
- Reset values: `ped=0`, `wait_lamp=0`, `btn_clean=0`, `press_cnt=0`; `s1`, `s2`, `btn_clean_d`, `dc`, `hc` all 0; state IDLE.
- Press latency with `btn_raw` rising just before edge 1:
  - `s2=1` after edge 2.
  - `btn_clean` rises after edge 2+`DB_CYCLES`.
  - `ped` rises after edge 3+`DB_CYCLES` (7 with defaults).
- Release: debounced the same way; it has no effect on `ped`.
- `ped` falls on the edge after the first cycle `walk=1` is sampled in REQ.
- Hold-off: exactly `HOLDOFF` cycles in HOLD. A press pulse on the cycle the FSM returns to IDLE is accepted.
- Reset mid-operation: all state clears immediately and asynchronously. A button still held at release produces a new press after the normal latency, because `btn_clean` restarts at 0.

## Configuration
- `PED_PRESS_COUNT_EN` defined:
  - `press_cnt` is an 8-bit counter that increments on each IDLE->REQ transition.
  - It saturates at 255 and clears only on reset.
- `PED_PRESS_COUNT_EN` undefined:
  - No counter logic is built.
  - `press_cnt` is tied to 8'd0.

## Test plan
- Clean press, defaults: `btn_raw` 0->1 held 20 cycles -> `ped` and `wait_lamp` rise after edge 7; stay high until `walk` is asserted.
- Bounce: `btn_raw` toggles every 2 cycles for 12 cycles, then steady 1 -> no `btn_clean` change during the toggling; `ped` rises 7 edges after the last rising toggle.
- Serve and hold-off: in REQ, `walk=1` for 10 cycles then 0 -> `ped` falls next edge. A press during HOLD (8 cycles) is ignored; a press held across HOLD exit is accepted.
- Simultaneous: `walk=1` in the same cycle the press pulse arrives in IDLE -> REQ for one cycle (`ped=1`), then SERVE.
- Reset mid-request: `rst=0` while in REQ -> `ped=0` and `wait_lamp=0` immediately, without waiting for a clock. After release with the button held, `ped` reasserts after 7 edges.
- Counter: with `PED_PRESS_COUNT_EN` defined, run 300 served requests -> `press_cnt==255`. Without the macro -> `press_cnt==0` throughout.

Source files
------------

// File: rtl/ped_req_cond.sv
// Pedestrian request conditioner: synchronises and debounces the crossing button,
// holds a ped request until served, then blocks repeat presses for a hold-off window.
// Optional accepted-press counter is built only when PED_PRESS_COUNT_EN is defined.
`timescale 1ns/1ps
module ped_req_cond #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned HOLDOFF   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       walk,
  output logic       ped,
  output logic       wait_lamp,
  output logic       btn_clean,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLD} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [7:0] HO_LAST = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

  state_t     state, state_nxt;
  logic       s1, s2, btn_clean_d;
  logic [7:0] dc, hc;
  logic       press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      dc          <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      btn_clean_d <= btn_clean;
      if (s2 == btn_clean) begin
        dc <= '0;
      end else if (dc == DB_LAST) begin
        btn_clean <= s2;
        dc        <= '0;
      end else begin
        dc <= dc + 8'd1;
      end
    end
  end

  assign press = btn_clean & ~btn_clean_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (press) state_nxt = REQ;
      REQ:     if (walk) state_nxt = SERVE;
      SERVE:   if (!walk) state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (hc == HO_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hc        <= '0;
      ped       <= 1'b0;
      wait_lamp <= 1'b0;
    end else begin
      state     <= state_nxt;
      ped       <= (state_nxt == REQ);
      wait_lamp <= (state_nxt == REQ);
      // hc is parked at zero while serving so HOLD always starts a fresh count
      if (state == SERVE) begin
        hc <= '0;
      end else if (state == HOLD) begin
        hc <= hc + 8'd1;
      end
    end
  end

`ifdef PED_PRESS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_cnt <= '0;
    end else if (state == IDLE && state_nxt == REQ && press_cnt != 8'hFF) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end
`else
  assign press_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ped_req_cond.sv
// Self-checking bench for ped_req_cond: event-level model compared every cycle,
// plus directed latency/boundary checks with hand-computed values.
`timescale 1ns/1ps
module tb_ped_req_cond;

  localparam int DB = 4;
  localparam int HO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       walk = 1'b0;
  logic       ped, wait_lamp, btn_clean;
  logic [7:0] press_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int e;

  ped_req_cond #(.DB_CYCLES(DB), .HOLDOFF(HO)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .walk      (walk),
    .ped       (ped),
    .wait_lamp (wait_lamp),
    .btn_clean (btn_clean),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: button history, run length of disagreement, request/serve/hold-off phases.
  bit m_s1, m_s2, m_clean, m_clean_d, m_press;
  bit m_pending, m_serving;
  int m_run = 0, m_hold_left = 0, m_count = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_clean_d = 0; m_run = 0;
      m_pending = 0; m_serving = 0; m_hold_left = 0; m_count = 0;
    end else begin
      m_press   = m_clean && !m_clean_d;
      m_clean_d = m_clean;
      if (m_s2 != m_clean) begin
        m_run++;
        if (m_run == DB) begin
          m_clean = m_s2;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      if (m_pending) begin
        if (walk) begin m_pending = 0; m_serving = 1; end
      end else if (m_serving) begin
        if (!walk) begin m_serving = 0; m_hold_left = HO; end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (m_press) begin
        m_pending = 1;
        if (m_count < 255) m_count++;
      end
    end
  end

  function automatic logic [7:0] exp_cnt();
`ifdef PED_PRESS_COUNT_EN
    return 8'(m_count);
`else
    return 8'd0;
`endif
  endfunction

  always @(negedge clk) begin
    check("ped_vs_model", ped, m_pending);
    check("wait_vs_model", wait_lamp, m_pending);
    check("clean_vs_model", btn_clean, m_clean);
    check("cnt_vs_model", press_cnt, exp_cnt());
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts rising edges until ped reaches lvl; -1 if the budget runs out.
  task automatic edges_until_ped(input logic lvl, input int budget, output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (ped !== lvl && edges < budget);
    if (ped !== lvl) edges = -1;
  endtask

  task automatic finish_service();
    btn_raw = 1'b0;
    step(8);
    walk = 1'b1;
    step(2);
    walk = 1'b0;
    step(12);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    step(3);
    check("rst_ped", ped, 0);
    check("rst_wait", wait_lamp, 0);
    check("rst_clean", btn_clean, 0);
    check("rst_cnt", press_cnt, 0);
    rst = 1'b1;
    step(2);

    // clean press, held 20 cycles
    btn_raw = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("clean_latency", e, 7);
    check("clean_wait", wait_lamp, 1);
    step(13);
    check("ped_held", ped, 1);
    btn_raw = 1'b0;
    step(10);
    check("release_no_effect", ped, 1);
    check("release_clean", btn_clean, 0);

    // serve; press pulse lands on the last HOLD cycle -> ignored
    walk = 1'b1;
    step(1);
    check("ped_fall", ped, 0);
    step(9);
    walk = 1'b0;
    step(2);
    btn_raw = 1'b1;
    step(14);
    check("hold_press_ignored", ped, 0);
    btn_raw = 1'b0;
    step(10);

    // new request; press pulse lands on the first IDLE cycle after HOLD -> accepted
    btn_raw = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("second_latency", e, 7);
    btn_raw = 1'b0;
    step(8);
    walk = 1'b1;
    step(3);
    walk = 1'b0;
    step(3);
    btn_raw = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("holdexit_latency", e, 7);
    finish_service();

    // press and walk in the same IDLE cycle
    btn_raw = 1'b1;
    step(6);
    walk = 1'b1;
    step(1);
    check("simul_req", ped, 1);
    step(1);
    check("simul_serve", ped, 0);
    walk = 1'b0;
    btn_raw = 1'b0;
    step(14);

    // bounce: toggling every 2 cycles never settles
    for (int i = 0; i < 12; i++) begin
      btn_raw = (((i / 2) % 2) == 0);
      step(1);
      check("bounce_clean", btn_clean, 0);
    end
    btn_raw = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("bounce_latency", e, 7);
    finish_service();

    // asynchronous reset while in REQ, button still held
    btn_raw = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("pre_rst_latency", e, 7);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ped", ped, 0);
    check("async_rst_wait", wait_lamp, 0);
    check("async_rst_clean", btn_clean, 0);
    step(2);
    rst = 1'b1;
    edges_until_ped(1'b1, 20, e);
    check("rst_repress_latency", e, 7);
    finish_service();

    // 300 served requests for the press counter
    for (int r = 0; r < 300; r++) begin
      btn_raw = 1'b1;
      edges_until_ped(1'b1, 20, e);
      check("loop_latency", e, 7);
      btn_raw = 1'b0;
      walk = 1'b1;
      step(2);
      walk = 1'b0;
      step(12);
    end
`ifdef PED_PRESS_COUNT_EN
    check("cnt_saturated", press_cnt, 255);
`else
    check("cnt_tied_zero", press_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
